// File: rtl/mem_arbiter.sv
// Shares one synchronous single-port SRAM between instruction-fetch and data ports.
// Latency: 3 cycles from the request-sampling edge to the one-cycle ack pulse.
// Backpressure: requests hold until ack; data wins ties unless fetch has waited MAX_DATA_RUN grants.
module mem_arbiter #(
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic [31:0] m_addr,
    output logic [3:0]  m_we,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  run_cnt;
    logic        is_write;
    logic        i_elig;
    logic        d_elig;
    logic        grant_i;
    logic        grant_d;

    // Pick a winner in IDLE; a port in its own ack cycle sits out so it is never served twice.
    always_comb begin
        i_elig    = i_req && !i_ack;
        d_elig    = d_req && !d_ack;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (d_elig && (!i_elig || run_cnt != RUN_MAX)) begin
                    grant_d = 1'b1;
                end else if (i_elig) begin
                    grant_i = 1'b1;
                end
                if (grant_d || grant_i) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory command, response capture, ack pulses and the fetch-starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_addr   <= '0;
            m_we     <= '0;
            m_wdata  <= '0;
            owner    <= 1'b0;
            is_write <= 1'b0;
            run_cnt  <= '0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            i_ack    <= 1'b0;
            d_ack    <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        m_addr   <= d_addr;
                        m_we     <= d_we;
                        m_wdata  <= d_wdata;
                        owner    <= 1'b1;
                        is_write <= |d_we;
                        // Only count data wins that actually kept a fetch waiting.
                        if (i_elig) begin
                            run_cnt <= (run_cnt >= RUN_MAX) ? RUN_MAX : run_cnt + 4'd1;
                        end else begin
                            run_cnt <= '0;
                        end
                    end else if (grant_i) begin
                        m_addr   <= i_addr;
                        m_we     <= '0;
                        m_wdata  <= '0;
                        owner    <= 1'b0;
                        is_write <= 1'b0;
                        run_cnt  <= '0;
                    end
                end
                ISSUE: begin
                    // The SRAM has taken the write at this edge; never let it repeat.
                    m_we <= '0;
                end
                RESP: begin
                    if (!owner) begin
                        i_rdata <= m_rdata;
                        i_ack   <= 1'b1;
                    end else begin
                        d_ack <= 1'b1;
                        if (!is_write) begin
                            d_rdata <= m_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port SRAM.
// Per-cycle vector table for the basic flows, then hand sequences for starvation and reset.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_mem_arbiter;

    localparam logic [31:0] A_I0 = 32'h0000_0010;
    localparam logic [31:0] A_I1 = 32'h0000_0014;
    localparam logic [31:0] A_D  = 32'h0000_0100;
    localparam logic [31:0] W0   = 32'h0050_0093;
    localparam logic [31:0] W1   = 32'h1234_5678;
    localparam logic [31:0] DB   = 32'hDEAD_BEEF;
    localparam logic [31:0] Z    = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic [31:0] m_addr;
    logic [3:0]  m_we;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        owner;

    logic        mem_load;
    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.MAX_DATA_RUN(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ack   (i_ack),
        .d_req   (d_req),
        .d_addr  (d_addr),
        .d_we    (d_we),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ack   (d_ack),
        .m_addr  (m_addr),
        .m_we    (m_we),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .owner   (owner)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM: byte writes and a registered read of the sampled address.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
            mem[4] <= W0;
            mem[5] <= W1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (m_we[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
        end
        m_rdata <= mem[m_addr[9:2]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic [31:0] da;
        logic [3:0]  dw;
        logic [31:0] dd;
        logic        x_iack;
        logic        x_dack;
        logic        x_own;
        logic [3:0]  x_we;
        logic [31:0] x_maddr;
        logic [31:0] x_irdata;
        logic [31:0] x_drdata;
    } vec_t;

    function automatic vec_t v(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic [31:0] da, input logic [3:0] dw, input logic [31:0] dd,
                               input logic xia, input logic xda, input logic xow,
                               input logic [3:0] xwe, input logic [31:0] xma,
                               input logic [31:0] xir, input logic [31:0] xdr);
        vec_t r;
        r.ir = ir; r.ia = ia; r.dr = dr; r.da = da; r.dw = dw; r.dd = dd;
        r.x_iack = xia; r.x_dack = xda; r.x_own = xow; r.x_we = xwe;
        r.x_maddr = xma; r.x_irdata = xir; r.x_drdata = xdr;
        return r;
    endfunction

    // Both ports request in a quiet IDLE cycle; the loser withdraws so the next round starts quiet.
    task automatic race_round(input int idx, input logic exp_owner);
        @(negedge clk);
        i_req = 1'b1; i_addr = A_I0; d_req = 1'b1; d_addr = A_D; d_we = 4'h0;
        @(posedge clk); #1;
        check($sformatf("round%0d.owner", idx), {31'h0, owner}, {31'h0, exp_owner});
        check($sformatf("round%0d.m_addr", idx), m_addr, exp_owner ? A_D : A_I0);
        @(negedge clk);
        if (exp_owner) i_req = 1'b0; else d_req = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check($sformatf("round%0d.ack", idx), {30'h0, i_ack, d_ack},
              exp_owner ? 32'h1 : 32'h2);
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
    endtask

    vec_t vt [27];

    initial begin
        int   both_acks;
        int   n_acks;
        logic [3:0] seq;
        int   lat;

        rst = 1'b1; mem_load = 1'b1;
        i_req = 1'b0; i_addr = Z; d_req = 1'b0; d_addr = Z; d_we = 4'h0; d_wdata = Z;

        //           ir    ia    dr    da   dw    dd  | iack  dack  own   we    m_addr i_rdata d_rdata
        vt[0]  = v(1'b1, A_I0, 1'b0, Z,   4'h0, Z,  1'b0, 1'b0, 1'b0, 4'h0, A_I0, Z,  Z);
        vt[1]  = v(1'b1, A_I0, 1'b0, Z,   4'h0, Z,  1'b0, 1'b0, 1'b0, 4'h0, A_I0, Z,  Z);
        vt[2]  = v(1'b1, A_I0, 1'b0, Z,   4'h0, Z,  1'b1, 1'b0, 1'b0, 4'h0, A_I0, W0, Z);
        vt[3]  = v(1'b0, A_I0, 1'b0, Z,   4'h0, Z,  1'b0, 1'b0, 1'b0, 4'h0, A_I0, W0, Z);
        // Write then read-back of the same word.
        vt[4]  = v(1'b0, A_I0, 1'b1, A_D, 4'hf, DB, 1'b0, 1'b0, 1'b1, 4'hf, A_D,  W0, Z);
        vt[5]  = v(1'b0, A_I0, 1'b1, A_D, 4'hf, DB, 1'b0, 1'b0, 1'b1, 4'h0, A_D,  W0, Z);
        vt[6]  = v(1'b0, A_I0, 1'b1, A_D, 4'hf, DB, 1'b0, 1'b1, 1'b1, 4'h0, A_D,  W0, Z);
        vt[7]  = v(1'b0, A_I0, 1'b1, A_D, 4'h0, Z,  1'b0, 1'b0, 1'b1, 4'h0, A_D,  W0, Z);
        vt[8]  = v(1'b0, A_I0, 1'b1, A_D, 4'h0, Z,  1'b0, 1'b0, 1'b1, 4'h0, A_D,  W0, Z);
        vt[9]  = v(1'b0, A_I0, 1'b1, A_D, 4'h0, Z,  1'b0, 1'b0, 1'b1, 4'h0, A_D,  W0, Z);
        vt[10] = v(1'b0, A_I0, 1'b1, A_D, 4'h0, Z,  1'b0, 1'b1, 1'b1, 4'h0, A_D,  W0, DB);
        vt[11] = v(1'b0, A_I0, 1'b0, A_D, 4'h0, Z,  1'b0, 1'b0, 1'b1, 4'h0, A_D,  W0, DB);
        // Simultaneous requests: data first, fetch granted at the data ack edge.
        vt[12] = v(1'b1, A_I1, 1'b1, A_D, 4'h0, Z,  1'b0, 1'b0, 1'b1, 4'h0, A_D,  W0, DB);
        vt[13] = v(1'b1, A_I1, 1'b1, A_D, 4'h0, Z,  1'b0, 1'b0, 1'b1, 4'h0, A_D,  W0, DB);
        vt[14] = v(1'b1, A_I1, 1'b1, A_D, 4'h0, Z,  1'b0, 1'b1, 1'b1, 4'h0, A_D,  W0, DB);
        vt[15] = v(1'b1, A_I1, 1'b0, A_D, 4'h0, Z,  1'b0, 1'b0, 1'b0, 4'h0, A_I1, W0, DB);
        vt[16] = v(1'b1, A_I1, 1'b0, A_D, 4'h0, Z,  1'b0, 1'b0, 1'b0, 4'h0, A_I1, W0, DB);
        vt[17] = v(1'b1, A_I1, 1'b0, A_D, 4'h0, Z,  1'b1, 1'b0, 1'b0, 4'h0, A_I1, W1, DB);
        vt[18] = v(1'b0, A_I1, 1'b0, A_D, 4'h0, Z,  1'b0, 1'b0, 1'b0, 4'h0, A_I1, W1, DB);
        // Fetch held through its ack: no grant in the ack cycle, re-grant the cycle after.
        vt[19] = v(1'b1, A_I0, 1'b0, A_D, 4'h0, Z,  1'b0, 1'b0, 1'b0, 4'h0, A_I0, W1, DB);
        vt[20] = v(1'b1, A_I0, 1'b0, A_D, 4'h0, Z,  1'b0, 1'b0, 1'b0, 4'h0, A_I0, W1, DB);
        vt[21] = v(1'b1, A_I0, 1'b0, A_D, 4'h0, Z,  1'b1, 1'b0, 1'b0, 4'h0, A_I0, W0, DB);
        vt[22] = v(1'b1, A_I1, 1'b0, A_D, 4'h0, Z,  1'b0, 1'b0, 1'b0, 4'h0, A_I0, W0, DB);
        vt[23] = v(1'b1, A_I1, 1'b0, A_D, 4'h0, Z,  1'b0, 1'b0, 1'b0, 4'h0, A_I1, W0, DB);
        vt[24] = v(1'b1, A_I1, 1'b0, A_D, 4'h0, Z,  1'b0, 1'b0, 1'b0, 4'h0, A_I1, W0, DB);
        vt[25] = v(1'b1, A_I1, 1'b0, A_D, 4'h0, Z,  1'b1, 1'b0, 1'b0, 4'h0, A_I1, W1, DB);
        vt[26] = v(1'b0, A_I1, 1'b0, A_D, 4'h0, Z,  1'b0, 1'b0, 1'b0, 4'h0, A_I1, W1, DB);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst.i_ack",   {31'h0, i_ack}, 32'h0);
        check("rst.d_ack",   {31'h0, d_ack}, 32'h0);
        check("rst.owner",   {31'h0, owner}, 32'h0);
        check("rst.m_we",    {28'h0, m_we},  32'h0);
        check("rst.m_addr",  m_addr,  Z);
        check("rst.m_wdata", m_wdata, Z);
        check("rst.i_rdata", i_rdata, Z);
        check("rst.d_rdata", d_rdata, Z);
        @(negedge clk);
        rst = 1'b0; mem_load = 1'b0;

        for (int k = 0; k < 27; k++) begin
            i_req = vt[k].ir; i_addr = vt[k].ia; d_req = vt[k].dr;
            d_addr = vt[k].da; d_we = vt[k].dw; d_wdata = vt[k].dd;
            @(posedge clk); #1;
            check($sformatf("vec%0d.i_ack", k),   {31'h0, i_ack}, {31'h0, vt[k].x_iack});
            check($sformatf("vec%0d.d_ack", k),   {31'h0, d_ack}, {31'h0, vt[k].x_dack});
            check($sformatf("vec%0d.owner", k),   {31'h0, owner}, {31'h0, vt[k].x_own});
            check($sformatf("vec%0d.m_we", k),    {28'h0, m_we},  {28'h0, vt[k].x_we});
            check($sformatf("vec%0d.m_addr", k),  m_addr,  vt[k].x_maddr);
            check($sformatf("vec%0d.i_rdata", k), i_rdata, vt[k].x_irdata);
            check($sformatf("vec%0d.d_rdata", k), d_rdata, vt[k].x_drdata);
            @(negedge clk);
        end
        check("write.m_wdata_mem", mem[64], DB);

        // Starvation bound: four data wins over a waiting fetch, then fetch wins,
        // and the fetch grant clears the count so data wins the next tie again.
        race_round(1, 1'b1);
        race_round(2, 1'b1);
        race_round(3, 1'b1);
        race_round(4, 1'b1);
        race_round(5, 1'b0);
        race_round(6, 1'b1);

        // Both held continuously: ack-cycle ineligibility alternates ownership.
        @(negedge clk);
        i_req = 1'b1; i_addr = A_I0; d_req = 1'b1; d_addr = A_D; d_we = 4'h0;
        both_acks = 0; n_acks = 0; seq = 4'h0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (i_ack && d_ack) both_acks++;
            if (d_ack) begin seq = {seq[2:0], 1'b1}; n_acks++; end
            if (i_ack) begin seq = {seq[2:0], 1'b0}; n_acks++; end
        end
        check("held.both_acks", both_acks, 0);
        check("held.n_acks",    n_acks,    4);
        check("held.order",     {28'h0, seq}, 32'ha);
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;
        repeat (4) @(posedge clk);

        // Reset during the ISSUE cycle of a write.
        @(negedge clk);
        d_req = 1'b1; d_addr = 32'h200; d_we = 4'hf; d_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        check("rstw.m_we_issue", {28'h0, m_we}, 32'hf);
        #2 rst = 1'b1;
        #1;
        check("rstw.m_we_async", {28'h0, m_we}, 32'h0);
        check("rstw.owner",      {31'h0, owner}, 32'h0);
        @(negedge clk);
        d_req = 1'b0; d_we = 4'h0;
        lat = 0;
        repeat (2) begin @(posedge clk); #1; if (d_ack) lat++; end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (d_ack) lat++; end
        check("rstw.no_ack", lat, 0);
        check("rstw.mem_untouched", mem[128], Z);

        // First request after reset completes normally.
        @(negedge clk);
        d_req = 1'b1; d_addr = A_D; d_we = 4'h0;
        lat = 0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (d_ack && lat == 0) lat = c;
            if (c == 3) begin
                @(negedge clk);
                d_req = 1'b0;
            end
        end
        check("post_rst.latency", lat, 3);
        check("post_rst.d_rdata", d_rdata, DB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
